// File: rtl/pipe_pkg.sv
// Shared state encoding, forwarding-select encodings and widths for the hazard controller.
package pipe_pkg;

    localparam int AW = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MUL_WAIT   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Instruction word the pipeline registers load for a bubble or flush (sll r0, r0, 0).
    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Per-source hazard detection against EX/MEM/WB destinations and forwarding select (MEM over WB).
module pipe_fwd_unit
    import pipe_pkg::*;
#(
    parameter int AW_P = pipe_pkg::AW
) (
    input  logic [AW_P-1:0] src_i,
    input  logic            use_i,
    input  logic [AW_P-1:0] ex_wr_addr_i,
    input  logic            ex_reg_wr_i,
    input  logic [AW_P-1:0] mem_wr_addr_i,
    input  logic            mem_reg_wr_i,
    input  logic [AW_P-1:0] wb_wr_addr_i,
    input  logic            wb_reg_wr_i,
    output logic            hit_ex_o,
    output logic            hit_mem_o,
    output logic            hit_wb_o,
    output logic [1:0]      fwd_o
);

    // r0 is hard-wired zero, so it can never be a real dependency.
    logic src_live;
    assign src_live = use_i & (src_i != '0);

    assign hit_ex_o  = src_live & ex_reg_wr_i  & (ex_wr_addr_i  == src_i);
    assign hit_mem_o = src_live & mem_reg_wr_i & (mem_wr_addr_i == src_i);
    assign hit_wb_o  = src_live & wb_reg_wr_i  & (wb_wr_addr_i  == src_i);

    assign fwd_o = hit_mem_o ? FWD_MEM :
                   hit_wb_o  ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush/forwarding scheduler for the 5-stage pipeline, including MUL sequencing.
// Build option PIPE_FWD_EN: defined -> operand forwarding; undefined -> stall on any source hit.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int AW      = pipe_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_is_mul,
    input  logic [AW-1:0] ex_wr_addr,
    input  logic          ex_reg_wr,
    input  logic          ex_mem_read,
    input  logic [AW-1:0] mem_wr_addr,
    input  logic          mem_reg_wr,
    input  logic [AW-1:0] wb_wr_addr,
    input  logic          wb_reg_wr,
    input  logic          ex_redirect,
    output logic          pc_stall,
    output logic          ifid_stall,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic          mul_start,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          busy
);

    localparam int CW = $clog2(MUL_LAT);

    state_e        state_q, state_d;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    logic          active_q;

    logic       a_hit_ex, a_hit_mem, a_hit_wb;
    logic       b_hit_ex, b_hit_mem, b_hit_wb;
    logic [1:0] a_fwd, b_fwd;
    logic       hazard;

    pipe_fwd_unit #(.AW_P(AW)) u_fwd_a (
        .src_i         (id_rs),
        .use_i         (id_use_rs),
        .ex_wr_addr_i  (ex_wr_addr),
        .ex_reg_wr_i   (ex_reg_wr),
        .mem_wr_addr_i (mem_wr_addr),
        .mem_reg_wr_i  (mem_reg_wr),
        .wb_wr_addr_i  (wb_wr_addr),
        .wb_reg_wr_i   (wb_reg_wr),
        .hit_ex_o      (a_hit_ex),
        .hit_mem_o     (a_hit_mem),
        .hit_wb_o      (a_hit_wb),
        .fwd_o         (a_fwd)
    );

    pipe_fwd_unit #(.AW_P(AW)) u_fwd_b (
        .src_i         (id_rt),
        .use_i         (id_use_rt),
        .ex_wr_addr_i  (ex_wr_addr),
        .ex_reg_wr_i   (ex_reg_wr),
        .mem_wr_addr_i (mem_wr_addr),
        .mem_reg_wr_i  (mem_reg_wr),
        .wb_wr_addr_i  (wb_wr_addr),
        .wb_reg_wr_i   (wb_reg_wr),
        .hit_ex_o      (b_hit_ex),
        .hit_mem_o     (b_hit_mem),
        .hit_wb_o      (b_hit_wb),
        .fwd_o         (b_fwd)
    );

`ifdef PIPE_FWD_EN
    // Only a load result still in EX cannot be forwarded in time.
    assign hazard = ex_mem_read & (a_hit_ex | b_hit_ex);
    assign fwd_a  = active_q ? a_fwd : FWD_RF;
    assign fwd_b  = active_q ? b_fwd : FWD_RF;

    logic unused_hits;
    assign unused_hits = ^{a_hit_mem, a_hit_wb, b_hit_mem, b_hit_wb};
`else
    // Without forwarding, wait until the producer has written the register file.
    assign hazard = a_hit_ex | a_hit_mem | a_hit_wb | b_hit_ex | b_hit_mem | b_hit_wb;
    assign fwd_a  = FWD_RF;
    assign fwd_b  = FWD_RF;

    logic unused_fwd;
    assign unused_fwd = ^{ex_mem_read, a_fwd, b_fwd};
`endif

    assign busy = (state_q != RUN);

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mul_start   = 1'b0;

        if (active_q) begin
            case (state_q)
                // LOAD_STALL judges the re-presented ID instruction by the same rules as RUN.
                RUN, LOAD_STALL: begin
                    if (ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = RUN;
                    end else if (hazard) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = LOAD_STALL;
                    end else if (id_is_mul) begin
                        mul_start   = 1'b1;
                        mul_cnt_d   = CW'(MUL_LAT - 1);
                        state_d     = MUL_WAIT;
                    end else begin
                        state_d     = RUN;
                    end
                end
                MUL_WAIT: begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    mul_cnt_d   = mul_cnt_q - CW'(1);
                    if (mul_cnt_q == CW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            active_q  <= 1'b0;
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            active_q  <= 1'b1;
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; expectations track the PIPE_FWD_EN build option.
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 3;
    localparam int AW      = 5;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs, id_rt, ex_wr_addr, mem_wr_addr, wb_wr_addr;
    logic          id_use_rs, id_use_rt, id_is_mul;
    logic          ex_reg_wr, ex_mem_read, mem_reg_wr, wb_reg_wr, ex_redirect;
    logic          pc_stall, ifid_stall, ifid_flush, idex_bubble, mul_start, busy;
    logic [1:0]    fwd_a, fwd_b;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_is_mul   (id_is_mul),
        .ex_wr_addr  (ex_wr_addr),
        .ex_reg_wr   (ex_reg_wr),
        .ex_mem_read (ex_mem_read),
        .mem_wr_addr (mem_wr_addr),
        .mem_reg_wr  (mem_reg_wr),
        .wb_wr_addr  (wb_wr_addr),
        .wb_reg_wr   (wb_reg_wr),
        .ex_redirect (ex_redirect),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .mul_start   (mul_start),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .busy        (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_q[$];
    string       name_q[$];

    // Packed as {pc_stall, ifid_stall, ifid_flush, idex_bubble, mul_start, fwd_a, fwd_b, busy}.
    function automatic logic [9:0] mk(input logic stall, input logic flush, input logic bubble,
                                      input logic start, input logic [1:0] fa, input logic [1:0] fb,
                                      input logic bsy);
        return {stall, stall, flush, bubble, start, fa, fb, bsy};
    endfunction

    localparam logic [9:0] Z = 10'b0;

    task automatic idle();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_mul = 1'b0;
        ex_wr_addr = '0; ex_reg_wr = 1'b0; ex_mem_read = 1'b0;
        mem_wr_addr = '0; mem_reg_wr = 1'b0;
        wb_wr_addr = '0; wb_reg_wr = 1'b0;
        ex_redirect = 1'b0;
    endtask

    task automatic ex_load(input logic [AW-1:0] a);
        ex_wr_addr = a; ex_reg_wr = 1'b1; ex_mem_read = 1'b1;
    endtask

    // Push expectation with the stimulus, pop and compare at the falling edge, realign after posedge.
    task automatic step(input string name, input logic [9:0] expv);
        logic [9:0] got, want;
        string      n;
        exp_q.push_back(expv);
        name_q.push_back(name);
        @(negedge clk);
        got  = {pc_stall, ifid_stall, ifid_flush, idex_bubble, mul_start, fwd_a, fwd_b, busy};
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b (stall,stall,flush,bubble,start,fa,fb,busy)",
                     n, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        idle();
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        step(name, Z);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        ex_load(5); id_rs = 5; id_use_rs = 1'b1;
        #1;
        step("reset_held", Z);
        rst_n = 1'b1;
        step("reset_first_cycle", Z);
        step("reset_then_load_use", mk(1, 0, 1, 0, 2'b00, 2'b00, 0));
        idle();
        step("after_load_stall", mk(0, 0, 0, 0, 2'b00, 2'b00, 1));
        step("reset_idle", Z);
    endtask

    task automatic test_load_use();
        idle(); ex_load(5); id_rs = 5; id_use_rs = 1'b1; id_rt = 6; id_use_rt = 1'b1;
        step("lu_stall", mk(1, 0, 1, 0, 2'b00, 2'b00, 0));
        idle(); mem_wr_addr = 5; mem_reg_wr = 1'b1;
        id_rs = 5; id_use_rs = 1'b1; id_rt = 6; id_use_rt = 1'b1;
        step("lu_fwd_mem", FWD ? mk(0, 0, 0, 0, 2'b01, 2'b00, 1) : mk(1, 0, 1, 0, 2'b00, 2'b00, 1));
        idle(); wb_wr_addr = 5; wb_reg_wr = 1'b1;
        id_rs = 5; id_use_rs = 1'b1; id_rt = 6; id_use_rt = 1'b1;
        step("lu_wb", FWD ? mk(0, 0, 0, 0, 2'b10, 2'b00, 0) : mk(1, 0, 1, 0, 2'b00, 2'b00, 1));
        idle(); id_rs = 5; id_use_rs = 1'b1;
        step("lu_regfile", FWD ? Z : mk(0, 0, 0, 0, 2'b00, 2'b00, 1));
        idle();
        step("lu_idle", Z);
    endtask

    task automatic test_mul();
        idle(); id_is_mul = 1'b1; id_rs = 1; id_use_rs = 1'b1; id_rt = 2; id_use_rt = 1'b1;
        step("mul_start", mk(0, 0, 0, 1, 2'b00, 2'b00, 0));
        // MUL sits in EX writing r9, dependent add waits in ID; a stray redirect must be ignored.
        idle(); ex_wr_addr = 9; ex_reg_wr = 1'b1; id_rs = 9; id_use_rs = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            step($sformatf("mul_wait_%0d", i), mk(1, 0, 1, 0, 2'b00, 2'b00, 1));
        end
        ex_redirect = 1'b0;
        step("mul_last_ex", FWD ? Z : mk(1, 0, 1, 0, 2'b00, 2'b00, 0));
        idle(); mem_wr_addr = 9; mem_reg_wr = 1'b1; id_rs = 9; id_use_rs = 1'b1;
        step("mul_fwd_mem", FWD ? mk(0, 0, 0, 0, 2'b01, 2'b00, 0) : mk(1, 0, 1, 0, 2'b00, 2'b00, 1));
        idle();
        step("mul_drain", FWD ? Z : mk(0, 0, 0, 0, 2'b00, 2'b00, 1));
        step("mul_idle", Z);
    endtask

    task automatic test_redirect();
        idle(); ex_load(5); id_rs = 5; id_use_rs = 1'b1;
        step("rd_load_stall", mk(1, 0, 1, 0, 2'b00, 2'b00, 0));
        ex_redirect = 1'b1;
        step("rd_in_load_stall", mk(0, 1, 1, 0, 2'b00, 2'b00, 1));
        idle();
        step("rd_back_to_run", Z);
        ex_load(5); id_rs = 5; id_use_rs = 1'b1; ex_redirect = 1'b1;
        step("rd_run_load", mk(0, 1, 1, 0, 2'b00, 2'b00, 0));
        idle(); id_is_mul = 1'b1; ex_redirect = 1'b1;
        step("rd_run_mul", mk(0, 1, 1, 0, 2'b00, 2'b00, 0));
        idle();
        step("rd_idle", Z);
    endtask

    task automatic test_r0_priority();
        idle(); ex_load(0); mem_wr_addr = 0; mem_reg_wr = 1'b1; wb_wr_addr = 0; wb_reg_wr = 1'b1;
        id_rs = 0; id_use_rs = 1'b1; id_rt = 0; id_use_rt = 1'b1;
        step("r0_no_hazard", Z);
        idle(); mem_wr_addr = 7; mem_reg_wr = 1'b1; wb_wr_addr = 7; wb_reg_wr = 1'b1;
        id_rs = 7; id_use_rs = 1'b1; id_rt = 7; id_use_rt = 1'b1;
        step("mem_over_wb", FWD ? mk(0, 0, 0, 0, 2'b01, 2'b01, 0) : mk(1, 0, 1, 0, 2'b00, 2'b00, 0));
        idle(); mem_wr_addr = 8; mem_reg_wr = 1'b1; wb_wr_addr = 7; wb_reg_wr = 1'b1;
        id_rs = 8; id_use_rs = 1'b1; id_rt = 7; id_use_rt = 1'b1;
        step("split_sources", FWD ? mk(0, 0, 0, 0, 2'b01, 2'b10, 0) : mk(1, 0, 1, 0, 2'b00, 2'b00, 1));
        idle(); ex_load(4); mem_wr_addr = 4; mem_reg_wr = 1'b1; id_rs = 4; id_rt = 4;
        step("unused_src", FWD ? Z : mk(0, 0, 0, 0, 2'b00, 2'b00, 1));
        step("r0_idle", Z);
    endtask

    task automatic test_load_and_mul();
        idle(); ex_load(5); id_is_mul = 1'b1; id_rs = 5; id_use_rs = 1'b1;
        step("lm_load_first", mk(1, 0, 1, 0, 2'b00, 2'b00, 0));
        idle(); mem_wr_addr = 5; mem_reg_wr = 1'b1; id_is_mul = 1'b1; id_rs = 5; id_use_rs = 1'b1;
        step("lm_mul_after", FWD ? mk(0, 0, 0, 1, 2'b01, 2'b00, 1) : mk(1, 0, 1, 0, 2'b00, 2'b00, 1));
        idle(); id_is_mul = !FWD;
        step("lm_next", FWD ? mk(1, 0, 1, 0, 2'b00, 2'b00, 1) : mk(0, 0, 0, 1, 2'b00, 2'b00, 1));
        drain("lm_drain", MUL_LAT + 4);
    endtask

    task automatic test_mem_wb_chain();
        idle(); mem_wr_addr = 3; mem_reg_wr = 1'b1; id_rs = 3; id_use_rs = 1'b1;
        step("chain_mem", FWD ? mk(0, 0, 0, 0, 2'b01, 2'b00, 0) : mk(1, 0, 1, 0, 2'b00, 2'b00, 0));
        idle(); wb_wr_addr = 3; wb_reg_wr = 1'b1; id_rs = 3; id_use_rs = 1'b1;
        step("chain_wb", FWD ? mk(0, 0, 0, 0, 2'b10, 2'b00, 0) : mk(1, 0, 1, 0, 2'b00, 2'b00, 1));
        idle(); id_rs = 3; id_use_rs = 1'b1;
        step("chain_rf", FWD ? Z : mk(0, 0, 0, 0, 2'b00, 2'b00, 1));
        step("chain_idle", Z);
    endtask

    task automatic test_reset_mid_mul();
        idle(); id_is_mul = 1'b1;
        step("rm_start", mk(0, 0, 0, 1, 2'b00, 2'b00, 0));
        idle();
        rst_n = 1'b0;
        step("rm_in_reset", Z);
        rst_n = 1'b1;
        step("rm_first_after", Z);
        step("rm_run", Z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_redirect();
        test_r0_priority();
        test_load_and_mul();
        test_mem_wb_chain();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
